// File: rtl/cache_victim_allocator.sv
// cache_victim_allocator
//   Picks the line to fill on a cache miss and owns the per-line valid/dirty state.
//   The lowest-index invalid line wins; with every line valid, the replacement
//   algorithm's candidate is taken, and it is written back first if it is dirty.
//   Every hit and every allocation is reported to the replacement algorithm as a
//   one-cycle access pulse.
//
// Optional feature: define ALLOCATOR_INVALIDATE_EN to add the invalidateEnable and
//   invalidateCacheLine ports. Without it, lines only become invalid on reset.
//
// Ports (CW = COUNTER_WIDTH, N = NUMBER_OF_CACHE_LINES):
//   clock, reset              rising-edge clock; asynchronous active-high reset
//   allocateRequest           level, held by the requester until allocateGrant
//   allocateGrant             one-cycle pulse; the granted line is valid and clean
//   allocatedCacheLine [CW]   granted index; holds its value until the next grant
//   replacementCacheLine [CW] victim candidate from the replacement algorithm
//   accessEnable              one-cycle touch pulse to the replacement algorithm
//   lastAccessedCacheLine[CW] index being touched
//   hitEnable, hitCacheLine, hitWrite   cache hit this cycle; a write hit marks the line dirty
//   writeBackRequest          level; the victim in writeBackCacheLine must be written back
//   writeBackAck              one-cycle pulse; the write-back is complete
//   validMask, dirtyMask [N]  per-line valid and dirty bits
//   invalidateEnable, invalidateCacheLine  (ALLOCATOR_INVALIDATE_EN only)

module cache_victim_allocator #(
  parameter int unsigned NUMBER_OF_CACHE_LINES = 4,
  parameter int unsigned COUNTER_WIDTH = $clog2(NUMBER_OF_CACHE_LINES)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             allocateRequest,
  output logic                             allocateGrant,
  output logic [COUNTER_WIDTH-1:0]         allocatedCacheLine,
  input  logic [COUNTER_WIDTH-1:0]         replacementCacheLine,
  output logic                             accessEnable,
  output logic [COUNTER_WIDTH-1:0]         lastAccessedCacheLine,
  input  logic                             hitEnable,
  input  logic [COUNTER_WIDTH-1:0]         hitCacheLine,
  input  logic                             hitWrite,
  output logic                             writeBackRequest,
  output logic [COUNTER_WIDTH-1:0]         writeBackCacheLine,
  input  logic                             writeBackAck,
`ifdef ALLOCATOR_INVALIDATE_EN
  input  logic                             invalidateEnable,
  input  logic [COUNTER_WIDTH-1:0]         invalidateCacheLine,
`endif
  output logic [NUMBER_OF_CACHE_LINES-1:0] validMask,
  output logic [NUMBER_OF_CACHE_LINES-1:0] dirtyMask
);

  localparam int unsigned N  = NUMBER_OF_CACHE_LINES;
  localparam int unsigned CW = COUNTER_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SELECT    = 2'd1,
    ST_WRITEBACK = 2'd2,
    ST_GRANT     = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   victim_q, victim_d;
  logic [N-1:0]    valid_q, valid_d;
  logic [N-1:0]    dirty_q, dirty_d;
  logic            grant_q, grant_d;
  logic [CW-1:0]   alloc_line_q, alloc_line_d;
  logic            access_q, access_d;
  logic [CW-1:0]   last_line_q, last_line_d;
  logic            wb_req_q, wb_req_d;
  logic [CW-1:0]   wb_line_q, wb_line_d;

  logic            free_found;
  logic [CW-1:0]   free_idx;
  logic [CW-1:0]   select_victim;
  logic            go_grant;
  logic [CW-1:0]   grant_idx;

  // Lowest-index invalid line: scan downwards so the last hit is the lowest index.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = CW'(i);
      end
    end
  end

  assign select_victim = free_found ? free_idx : replacementCacheLine;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    grant_d      = 1'b0;
    alloc_line_d = alloc_line_q;
    access_d     = 1'b0;
    last_line_d  = last_line_q;
    wb_req_d     = 1'b0;
    wb_line_d    = wb_line_q;
    go_grant     = 1'b0;
    grant_idx    = victim_q;

    case (state_q)
      ST_IDLE: begin
`ifdef ALLOCATOR_INVALIDATE_EN
        if (invalidateEnable) begin
          valid_d[invalidateCacheLine] = 1'b0;
          dirty_d[invalidateCacheLine] = 1'b0;
        end else
`endif
        if (hitEnable) begin
          // Hit wins; a pending allocation simply waits in IDLE.
          access_d    = 1'b1;
          last_line_d = hitCacheLine;
          if (hitWrite) begin
            dirty_d[hitCacheLine] = 1'b1;
          end
        end else if (allocateRequest) begin
          state_d = ST_SELECT;
        end
      end

      ST_SELECT: begin
        victim_d = select_victim;
        if (dirty_q[select_victim]) begin
          state_d   = ST_WRITEBACK;
          wb_req_d  = 1'b1;
          wb_line_d = select_victim;
        end else begin
          go_grant  = 1'b1;
          grant_idx = select_victim;
        end
      end

      ST_WRITEBACK: begin
        if (writeBackAck) begin
          dirty_d[victim_q] = 1'b0;
          go_grant          = 1'b1;
          grant_idx         = victim_q;
        end else begin
          wb_req_d = 1'b1;
        end
      end

      ST_GRANT: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Entering GRANT: the line becomes valid and clean in the grant cycle itself.
    if (go_grant) begin
      state_d            = ST_GRANT;
      grant_d            = 1'b1;
      alloc_line_d       = grant_idx;
      access_d           = 1'b1;
      last_line_d        = grant_idx;
      valid_d[grant_idx] = 1'b1;
      dirty_d[grant_idx] = 1'b0;
    end
  end

  // State and output registers; reset abandons any write-back in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      victim_q     <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      grant_q      <= 1'b0;
      alloc_line_q <= '0;
      access_q     <= 1'b0;
      last_line_q  <= '0;
      wb_req_q     <= 1'b0;
      wb_line_q    <= '0;
    end else begin
      state_q      <= state_d;
      victim_q     <= victim_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      grant_q      <= grant_d;
      alloc_line_q <= alloc_line_d;
      access_q     <= access_d;
      last_line_q  <= last_line_d;
      wb_req_q     <= wb_req_d;
      wb_line_q    <= wb_line_d;
    end
  end

  assign allocateGrant         = grant_q;
  assign allocatedCacheLine    = alloc_line_q;
  assign accessEnable          = access_q;
  assign lastAccessedCacheLine = last_line_q;
  assign writeBackRequest      = wb_req_q;
  assign writeBackCacheLine    = wb_line_q;
  assign validMask             = valid_q;
  assign dirtyMask             = dirty_q;

endmodule

// File: tb/tb_cache_victim_allocator.sv
`timescale 1ns/1ps
module tb_cache_victim_allocator;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          allocateRequest;
  logic          allocateGrant;
  logic [CW-1:0] allocatedCacheLine;
  logic [CW-1:0] replacementCacheLine;
  logic          accessEnable;
  logic [CW-1:0] lastAccessedCacheLine;
  logic          hitEnable;
  logic [CW-1:0] hitCacheLine;
  logic          hitWrite;
  logic          writeBackRequest;
  logic [CW-1:0] writeBackCacheLine;
  logic          writeBackAck;
  logic [N-1:0]  validMask;
  logic [N-1:0]  dirtyMask;
`ifdef ALLOCATOR_INVALIDATE_EN
  logic          invalidateEnable;
  logic [CW-1:0] invalidateCacheLine;
`endif

  cache_victim_allocator #(
    .NUMBER_OF_CACHE_LINES(N),
    .COUNTER_WIDTH(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .allocateRequest(allocateRequest),
    .allocateGrant(allocateGrant),
    .allocatedCacheLine(allocatedCacheLine),
    .replacementCacheLine(replacementCacheLine),
    .accessEnable(accessEnable),
    .lastAccessedCacheLine(lastAccessedCacheLine),
    .hitEnable(hitEnable),
    .hitCacheLine(hitCacheLine),
    .hitWrite(hitWrite),
    .writeBackRequest(writeBackRequest),
    .writeBackCacheLine(writeBackCacheLine),
    .writeBackAck(writeBackAck),
`ifdef ALLOCATOR_INVALIDATE_EN
    .invalidateEnable(invalidateEnable),
    .invalidateCacheLine(invalidateCacheLine),
`endif
    .validMask(validMask),
    .dirtyMask(dirtyMask)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int idx;
    int cyc;
  } exp_t;

  exp_t exp_grant[$];
  exp_t exp_access[$];

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every grant/access pulse is matched against the next expected entry.
  always @(negedge clock) begin
    if (!reset) begin
      if (allocateGrant) begin
        if (exp_grant.size() == 0) begin
          check("grant_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = exp_grant.pop_front();
          check("grant_line", int'(allocatedCacheLine), e.idx);
          check("grant_cycle", cyc, e.cyc);
        end
      end
      if (accessEnable) begin
        if (exp_access.size() == 0) begin
          check("access_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = exp_access.pop_front();
          check("access_line", int'(lastAccessedCacheLine), e.idx);
          check("access_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_grant(input int idx, input int c);
    exp_t e;
    e.idx = idx;
    e.cyc = c;
    exp_grant.push_back(e);
    exp_access.push_back(e);
  endtask

  task automatic push_access(input int idx, input int c);
    exp_t e;
    e.idx = idx;
    e.cyc = c;
    exp_access.push_back(e);
  endtask

  // Wait (bounded) for a grant, drop the request in the grant cycle, realign after the edge.
  task automatic wait_grant(output bit saw_wb);
    bit got;
    got = 1'b0;
    saw_wb = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clock);
      if (writeBackRequest) saw_wb = 1'b1;
      if (allocateGrant) got = 1'b1;
    end
    check("grant_seen", int'(got), 1);
    allocateRequest = 1'b0;
    tick();
  endtask

  task automatic wait_wb(output int wb_cyc);
    bit got;
    got = 1'b0;
    wb_cyc = -1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clock);
      if (writeBackRequest) begin
        got = 1'b1;
        wb_cyc = cyc;
      end
    end
    check("wb_seen", int'(got), 1);
  endtask

  task automatic alloc_clean(input int idx, input string name);
    bit saw;
    push_grant(idx, cyc + 2);
    allocateRequest = 1'b1;
    wait_grant(saw);
    check({name, "_no_wb"}, int'(saw), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int wb_c;
    bit saw;

    reset = 1'b1;
    allocateRequest = 1'b0;
    replacementCacheLine = '0;
    hitEnable = 1'b0;
    hitCacheLine = '0;
    hitWrite = 1'b0;
    writeBackAck = 1'b0;
`ifdef ALLOCATOR_INVALIDATE_EN
    invalidateEnable = 1'b0;
    invalidateCacheLine = '0;
`endif
    repeat (3) tick();

    // Reset state
    check("rst_valid", int'(validMask), 0);
    check("rst_dirty", int'(dirtyMask), 0);
    check("rst_grant", int'(allocateGrant), 0);
    check("rst_access", int'(accessEnable), 0);
    check("rst_wbreq", int'(writeBackRequest), 0);
    reset = 1'b0;
    tick();

    // 1: fill from empty -> lines 0..3 in order
    for (int i = 0; i < 4; i++) alloc_clean(i, "fill");
    check("fill_valid", int'(validMask), 4'b1111);
    check("fill_dirty", int'(dirtyMask), 0);

    // 2: all valid, clean candidate 2
    replacementCacheLine = 2'd2;
    alloc_clean(2, "clean_victim");

    // 3: write hit on line 1, then evict line 1 via write-back
    push_access(1, cyc + 1);
    hitEnable = 1'b1; hitCacheLine = 2'd1; hitWrite = 1'b1;
    tick();
    hitEnable = 1'b0; hitWrite = 1'b0;
    check("hitw_dirty", int'(dirtyMask), 4'b0010);
    replacementCacheLine = 2'd1;
    t = cyc;
    allocateRequest = 1'b1;
    wait_wb(wb_c);
    check("wb_cycle", wb_c, t + 2);
    check("wb_line", int'(writeBackCacheLine), 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      check("wb_held", int'(writeBackRequest), 1);
      check("wb_line_held", int'(writeBackCacheLine), 1);
      tick();
    end
    push_grant(1, cyc + 1);
    writeBackAck = 1'b1;
    tick();
    writeBackAck = 1'b0;
    check("wb_dropped", int'(writeBackRequest), 0);
    wait_grant(saw);
    check("wb_dirty_clear", int'(dirtyMask[1]), 0);
    check("wb_valid", int'(validMask), 4'b1111);

    // 4: hit and request together -> touch first, grant one cycle later than usual
    t = cyc;
    replacementCacheLine = 2'd0;
    push_access(3, t + 1);
    push_grant(0, t + 3);
    hitEnable = 1'b1; hitCacheLine = 2'd3; hitWrite = 1'b0;
    allocateRequest = 1'b1;
    tick();
    hitEnable = 1'b0;
    wait_grant(saw);
    check("hit_alloc_no_wb", int'(saw), 0);

    // 5: reset during write-back
    push_access(2, cyc + 1);
    hitEnable = 1'b1; hitCacheLine = 2'd2; hitWrite = 1'b1;
    tick();
    hitEnable = 1'b0; hitWrite = 1'b0;
    replacementCacheLine = 2'd2;
    allocateRequest = 1'b1;
    wait_wb(wb_c);
    check("rst_wb_line", int'(writeBackCacheLine), 2);
    tick();
    reset = 1'b1;
    #1;
    check("midwb_wbreq", int'(writeBackRequest), 0);
    check("midwb_valid", int'(validMask), 0);
    check("midwb_dirty", int'(dirtyMask), 0);
    check("midwb_grant", int'(allocateGrant), 0);
    allocateRequest = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    alloc_clean(0, "recover");
    for (int i = 1; i < 4; i++) alloc_clean(i, "refill");
    check("refill_valid", int'(validMask), 4'b1111);

`ifdef ALLOCATOR_INVALIDATE_EN
    // 6: invalidate line 3, then allocate with candidate 0 -> line 3
    invalidateEnable = 1'b1; invalidateCacheLine = 2'd3;
    tick();
    invalidateEnable = 1'b0;
    check("inv_valid", int'(validMask), 4'b0111);
    replacementCacheLine = 2'd0;
    alloc_clean(3, "inv_alloc");
`endif

    repeat (3) tick();
    check("grant_queue_empty", exp_grant.size(), 0);
    check("access_queue_empty", exp_access.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
